// File: rtl/span_coverage_walker.sv
// Walks a triangle bounding box in LANES-wide horizontal spans, stepping three edge functions
// incrementally and emitting one coverage mask per span. Define SPAN_EMPTY_SKIP_EN to drop all-zero spans.
module span_coverage_walker #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int LANES  = 4,
    parameter int EDGE_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [3*EDGE_W-1:0]        e_init,
    input  logic [3*EDGE_W-1:0]        e_dx,
    input  logic [3*EDGE_W-1:0]        e_dy,
    input  logic [2:0]                 top_left,
    input  logic [$clog2(WIDTH)-1:0]   bbox_min_x,
    input  logic [$clog2(WIDTH)-1:0]   bbox_max_x,
    input  logic [$clog2(HEIGHT)-1:0]  bbox_min_y,
    input  logic [$clog2(HEIGHT)-1:0]  bbox_max_y,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [$clog2(WIDTH)-1:0]   out_x,
    output logic [$clog2(HEIGHT)-1:0]  out_y,
    output logic [LANES-1:0]           out_mask,
    output logic [3*EDGE_W-1:0]        out_e,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int LW = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, LOAD, WALK} state_e;

    state_e                    state_q;
    logic signed [EDGE_W-1:0]  dx_q [3];
    logic signed [EDGE_W-1:0]  dxl_q [3];
    logic signed [EDGE_W-1:0]  dy_q [3];
    logic signed [EDGE_W-1:0]  row_e_q [3];
    logic signed [EDGE_W-1:0]  cur_e_q [3];
    logic [2:0]                tl_q;
    logic [XW-1:0]             min_x_q, max_x_q, cur_x_q;
    logic [YW-1:0]             min_y_q, max_y_q, cur_y_q;
    logic [XW-1:0]             out_x_q;
    logic [YW-1:0]             out_y_q;
    logic [LANES-1:0]          out_mask_q;
    logic [3*EDGE_W-1:0]       out_e_q;
    logic                      out_valid_q;

    logic [LANES-1:0]          span_mask_d;
    logic signed [EDGE_W-1:0]  lane_e;
    logic                      lane_ok;
    logic [XW:0]               span_end_x;
    logic                      row_more, last_span, emit, load_en, step;

    // Lane k sees E + k*A, built from shifted copies of A selected by the bits of k.
    always_comb begin
        span_mask_d = '0;
        lane_e      = '0;
        lane_ok     = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            lane_ok = ({1'b0, cur_x_q} + (XW+1)'(k)) <= {1'b0, max_x_q};
            for (int i = 0; i < 3; i++) begin
                lane_e = cur_e_q[i];
                for (int b = 0; b < LW; b++) begin
                    if (k[b]) lane_e = lane_e + (dx_q[i] << b);
                end
                if (!((lane_e > 0) || ((lane_e == '0) && tl_q[i]))) lane_ok = 1'b0;
            end
            span_mask_d[k] = lane_ok;
        end
    end

    // One extra bit keeps the span-end compare from wrapping near the screen edge.
    assign span_end_x = {1'b0, cur_x_q} + (XW+1)'(LANES);
    assign row_more   = span_end_x <= {1'b0, max_x_q};
    assign last_span  = !row_more && (cur_y_q == max_y_q);
    assign load_en    = !out_valid_q || out_ready;

`ifdef SPAN_EMPTY_SKIP_EN
    assign emit = |span_mask_d;
`else
    assign emit = 1'b1;
`endif

    // A skipped span needs no output slot, so it advances even under back-pressure.
    assign step = (state_q == WALK) && (load_en || !emit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tl_q        <= '0;
            min_x_q     <= '0;
            max_x_q     <= '0;
            cur_x_q     <= '0;
            min_y_q     <= '0;
            max_y_q     <= '0;
            cur_y_q     <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_mask_q  <= '0;
            out_e_q     <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                dx_q[i]    <= '0;
                dxl_q[i]   <= '0;
                dy_q[i]    <= '0;
                row_e_q[i] <= '0;
                cur_e_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking throughout; the later WALK load overrides this drain when both happen.
            if (out_valid_q && out_ready) out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        tl_q    <= top_left;
                        min_x_q <= bbox_min_x;
                        max_x_q <= bbox_max_x;
                        min_y_q <= bbox_min_y;
                        max_y_q <= bbox_max_y;
                        for (int i = 0; i < 3; i++) begin
                            row_e_q[i] <= e_init[i*EDGE_W +: EDGE_W];
                            dx_q[i]    <= e_dx[i*EDGE_W +: EDGE_W];
                            dxl_q[i]   <= e_dx[i*EDGE_W +: EDGE_W] << LW;
                            dy_q[i]    <= e_dy[i*EDGE_W +: EDGE_W];
                        end
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if ((min_x_q > max_x_q) || (min_y_q > max_y_q)) begin
                        state_q <= IDLE;
                    end else begin
                        cur_x_q <= min_x_q;
                        cur_y_q <= min_y_q;
                        for (int i = 0; i < 3; i++) cur_e_q[i] <= row_e_q[i];
                        state_q <= WALK;
                    end
                end
                WALK: begin
                    if (step) begin
                        if (emit) begin
                            out_x_q     <= cur_x_q;
                            out_y_q     <= cur_y_q;
                            out_mask_q  <= span_mask_d;
                            out_valid_q <= 1'b1;
                            for (int i = 0; i < 3; i++) out_e_q[i*EDGE_W +: EDGE_W] <= cur_e_q[i];
                        end
                        if (row_more) begin
                            cur_x_q <= span_end_x[XW-1:0];
                            for (int i = 0; i < 3; i++) cur_e_q[i] <= cur_e_q[i] + dxl_q[i];
                        end else begin
                            cur_y_q <= cur_y_q + 1'b1;
                            cur_x_q <= min_x_q;
                            for (int i = 0; i < 3; i++) begin
                                row_e_q[i] <= row_e_q[i] + dy_q[i];
                                cur_e_q[i] <= row_e_q[i] + dy_q[i];
                            end
                        end
                        if (last_span) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE) || out_valid_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_mask  = out_mask_q;
    assign out_e     = out_e_q;
    assign out_valid = out_valid_q;

endmodule
